// File: rtl/color_palette_mapper.sv
// Maps an iteration count to a packed multi-channel colour word.
// COLOR_ESCAPE_BLANK_EN: force black when the latched count equals MAX_ITER.
module color_palette_mapper #(
  parameter int IN_W     = 16,
  parameter int COEFF_W  = 16,
  parameter int PHASE_W  = 12,
  parameter int OUT_W    = 4,
  parameter int CHANNELS = 3,
  parameter logic [IN_W-1:0] MAX_ITER = IN_W'(16'hFFFF)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          do_color,
  input  logic [IN_W-1:0]               data_in,
  input  logic [CHANNELS*COEFF_W-1:0]   coeff,
  input  logic [CHANNELS*PHASE_W-1:0]   offset,
  output logic [CHANNELS*OUT_W-1:0]     data_out,
  output logic                          done,
  output logic                          busy
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW   = IN_W + COEFF_W;
  localparam int SH   = PHASE_W - 1 - OUT_W;

`ifdef COLOR_ESCAPE_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t                        state;
  logic [CH_W-1:0]               ch;
  logic [IN_W-1:0]               data_q;
  logic [CHANNELS*COEFF_W-1:0]   coeff_q;
  logic [CHANNELS*PHASE_W-1:0]   offset_q;
  logic [CHANNELS*OUT_W-1:0]     res_q;

  logic [COEFF_W-1:0]            cf;
  logic [PHASE_W-1:0]            of;
  logic [PHASE_W-1:0]            ph;
  logic [PHASE_W-2:0]            half;
  logic [OUT_W-1:0]              r;
  logic [OUT_W-1:0]              rv;
  logic [CHANNELS*OUT_W-1:0]     res_next;
  logic                          last;
  logic                          blank;

  // Select the active channel's coefficient and offset.
  always_comb begin
    cf = '0;
    of = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch == CH_W'(i)) begin
        cf = coeff_q[i*COEFF_W +: COEFF_W];
        of = offset_q[i*PHASE_W +: PHASE_W];
      end
    end
  end

  assign ph    = PHASE_W'(PW'(data_q) * PW'(cf)) + of;
  // Triangle fold: the upper half-period mirrors the lower one.
  assign half  = ph[PHASE_W-2:0] ^ {(PHASE_W-1){ph[PHASE_W-1]}};
  assign r     = OUT_W'(half >> SH);
  assign blank = BLANK_EN && (data_q == MAX_ITER);
  assign rv    = blank ? '0 : r;
  assign last  = (ch == CH_W'(CHANNELS - 1));

  // Merge the current channel result into the working word.
  always_comb begin
    res_next = res_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch == CH_W'(i)) begin
        res_next[i*OUT_W +: OUT_W] = rv;
      end
    end
  end

  // Control FSM, operand latch and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ch       <= '0;
      data_q   <= '0;
      coeff_q  <= '0;
      offset_q <= '0;
      res_q    <= '0;
      data_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (do_color) begin
            data_q   <= data_in;
            coeff_q  <= coeff;
            offset_q <= offset;
            ch       <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          res_q <= res_next;
          if (last) begin
            data_out <= res_next;
            state    <= DONE;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        DONE: begin
          if (!do_color) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done = (state == DONE);
  assign busy = (state == CALC);

endmodule

// File: tb/tb_color_palette_mapper.sv
// Bench for color_palette_mapper: directed cases plus random vectors
// against an arithmetic reference, on a 3-channel and an 8-channel build.
module tb_color_palette_mapper;

  logic         clk = 1'b0;
  logic         reset;
  logic         dc, dc8;
  logic [15:0]  din, din8;
  logic [47:0]  cf;
  logic [35:0]  of;
  logic [11:0]  dout;
  logic         done, busy;
  logic [127:0] cf8;
  logic [95:0]  of8;
  logic [63:0]  dout8;
  logic         done8, busy8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  color_palette_mapper dut (
    .clk(clk), .reset(reset), .do_color(dc),
    .data_in(din), .coeff(cf), .offset(of),
    .data_out(dout), .done(done), .busy(busy)
  );

  color_palette_mapper #(.OUT_W(8), .CHANNELS(8)) dut8 (
    .clk(clk), .reset(reset), .do_color(dc8),
    .data_in(din8), .coeff(cf8), .offset(of8),
    .data_out(dout8), .done(done8), .busy(busy8)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One channel: 0.5-0.5cos approximated by a folded ramp over the phase.
  function automatic longint unsigned mdl(longint unsigned d,
      longint unsigned c, longint unsigned o, int pw, int ow);
    longint unsigned full, ph, v;
    full = longint'(1) << pw;
    ph = (d * c + o) % full;
    if (ph < full / 2) v = ph;
    else v = full - 1 - ph;
    return v >> (pw - 1 - ow);
  endfunction

  function automatic bit is_blank(logic [15:0] d);
`ifdef COLOR_ESCAPE_BLANK_EN
    return d == 16'hFFFF;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] exp3(logic [15:0] d, logic [47:0] c,
                                       logic [35:0] o);
    logic [11:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      if (!is_blank(d))
        w[i*4 +: 4] = 4'(mdl(d, c[i*16 +: 16], o[i*12 +: 12], 12, 4));
    return w;
  endfunction

  function automatic logic [63:0] exp8(logic [15:0] d, logic [127:0] c,
                                       logic [95:0] o);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++)
      if (!is_blank(d))
        w[i*8 +: 8] = 8'(mdl(d, c[i*16 +: 16], o[i*12 +: 12], 12, 8));
    return w;
  endfunction

  task automatic xact3(string tag, logic [15:0] d, logic [47:0] c,
                       logic [35:0] o, logic [11:0] exp);
    int n;
    din = d; cf = c; of = o; dc = 1'b1;
    step();
    din = 16'($urandom);
    cf = {$urandom, $urandom};
    of = {$urandom, $urandom};
    n = 0;
    while (!done && n < 20) begin step(); n++; end
    chk({tag, "_lat"}, 64'(n), 64'd3);
    chk({tag, "_data"}, 64'(dout), 64'(exp));
    dc = 1'b0;
    step();
    chk({tag, "_idle"}, {62'd0, done, busy}, 64'd0);
  endtask

  task automatic xact8(string tag, logic [15:0] d, logic [127:0] c,
                       logic [95:0] o);
    int n;
    din8 = d; cf8 = c; of8 = o; dc8 = 1'b1;
    step();
    din8 = 16'($urandom);
    n = 0;
    while (!done8 && n < 30) begin step(); n++; end
    chk({tag, "_lat"}, 64'(n), 64'd8);
    chk({tag, "_data"}, dout8, exp8(d, c, o));
    dc8 = 1'b0;
    step();
    chk({tag, "_idle"}, {62'd0, done8, busy8}, 64'd0);
  endtask

  localparam logic [47:0] BC = {16'd0, 16'd512, 16'd256};
  localparam logic [35:0] BO = {12'h800, 12'h000, 12'h000};

  initial begin
    logic [15:0]  rd;
    logic [47:0]  rc;
    logic [35:0]  ro;
    logic [127:0] rc8;
    logic [95:0]  ro8;

    reset = 1'b0; dc = 1'b0; dc8 = 1'b0;
    din = '0; cf = '0; of = '0;
    din8 = '0; cf8 = '0; of8 = '0;
    #2;
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dout8", dout8, 64'd0);
    step();
    reset = 1'b1;
    step();

    xact3("basic", 16'd5, BC, BO, 12'hFBA);
    xact3("wrap0", 16'hFFFF, {3{16'hFFFF}}, {3{12'hFFF}},
`ifdef COLOR_ESCAPE_BLANK_EN
          12'h000);
`else
          12'h000);
`endif
    xact3("wrapF", 16'hFFFF, {3{16'hFFFF}}, {3{12'h7FF}},
`ifdef COLOR_ESCAPE_BLANK_EN
          12'h000);
`else
          12'hFFF);
`endif
    xact3("wrapF2", 16'h0FFF, {3{16'h0001}}, {3{12'h001}}, 12'h000);

    din = 16'd5; cf = BC; of = BO; dc = 1'b1;
    step();
    chk("hold_busy", 64'(busy), 64'd1);
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("hold_done", 64'(done), 64'(i >= 3));
    end
    dc = 1'b0;
    chk("hold_done_pre", 64'(done), 64'd1);
    step();
    chk("hold_release", {62'd0, done, busy}, 64'd0);

    din = 16'd5; cf = BC; of = BO; dc = 1'b1;
    step();
    dc = 1'b0;
    begin
      int n;
      n = 0;
      while (!done && n < 20) begin step(); n++; end
      chk("drop_lat", 64'(n), 64'd3);
    end
    chk("drop_data", 64'(dout), 64'h0FBA);
    step();
    chk("drop_single", 64'(done), 64'd0);

    din = 16'h1234; cf = {3{16'h0777}}; of = '0; dc = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("midrst_dout", 64'(dout), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    dc = 1'b0;
    step();
    reset = 1'b1;
    step(); step(); step();
    chk("postrst_idle", {62'd0, done, busy}, 64'd0);
    chk("postrst_dout", 64'(dout), 64'd0);

    xact3("escape", 16'hFFFF, BC, BO, exp3(16'hFFFF, BC, BO));

    for (int k = 0; k < 400; k++) begin
      rd = 16'($urandom);
      rc = {$urandom, $urandom};
      ro = {$urandom, $urandom};
      xact3("rand3", rd, rc, ro, exp3(rd, rc, ro));
    end

    for (int k = 0; k < 300; k++) begin
      rd  = 16'($urandom);
      rc8 = {$urandom, $urandom, $urandom, $urandom};
      ro8 = {$urandom, $urandom, $urandom};
      xact8("rand8", rd, rc8, ro8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
